// File: rtl/pic_interrupt_acknowledge_control_if.sv
// rtl/pic_interrupt_acknowledge_control_if.sv - CPU-side INT/INTA/vector bus between the CPU and the PIC acknowledge block
interface pic_interrupt_acknowledge_control_if;
  logic       inta_n;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (output inta_n, input int_out, input data_out, input data_out_en);
  modport slave  (input inta_n, output int_out, output data_out, output data_out_en);
endinterface

// File: rtl/pic_interrupt_acknowledge_control.sv
// rtl/pic_interrupt_acknowledge_control.sv - INT/INTA acknowledge sequencer, in-service register and OCW2 EOI/rotate handling
module pic_interrupt_acknowledge_control #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [7:0]                           interrupt,
  input  logic                                 init_strobe,
  input  logic                                 aeoi_mode,
  input  logic [4:0]                           vector_base,
  input  logic                                 ocw2_strobe,
  input  logic [7:0]                           ocw2,
  pic_interrupt_acknowledge_control_if.slave   cpu,
  output logic [7:0]                           clear_irr,
  output logic [7:0]                           isr,
  output logic [7:0]                           highest_level_in_service,
  output logic [2:0]                           priority_rotate
);

  typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK1_DONE, S_ACK2} state_e;

  state_e     state_q, state_d;
  logic       inta_n_q;
  logic       int_out_q, int_out_d;
  logic [7:0] clear_irr_q, clear_irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] priority_rotate_q, priority_rotate_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_out_en_q, data_out_en_d;
  logic       rotate_aeoi_q, rotate_aeoi_d;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;

  logic       inta_fall, inta_rise;
  logic [7:0] ack_set, eoi_clear;
  logic [7:0] hlis;
  logic [2:0] hlis_idx, scan_idx, irq_level;
  logic       hlis_valid;
  logic       unused_ocw2;

  // OCW2 bits 4:3 carry no meaning for this block
  assign unused_ocw2 = ^ocw2[4:3];

  assign inta_fall = inta_n_q & ~cpu.inta_n;
  assign inta_rise = ~inta_n_q & cpu.inta_n;

  // All state flops; reset aborts any acknowledge in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      inta_n_q          <= 1'b1;
      int_out_q         <= 1'b0;
      clear_irr_q       <= '0;
      isr_q             <= '0;
      priority_rotate_q <= 3'b111;
      data_out_q        <= '0;
      data_out_en_q     <= 1'b0;
      rotate_aeoi_q     <= 1'b0;
      level_q           <= '0;
      spurious_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      inta_n_q          <= cpu.inta_n;
      int_out_q         <= int_out_d;
      clear_irr_q       <= clear_irr_d;
      isr_q             <= isr_d;
      priority_rotate_q <= priority_rotate_d;
      data_out_q        <= data_out_d;
      data_out_en_q     <= data_out_en_d;
      rotate_aeoi_q     <= rotate_aeoi_d;
      level_q           <= level_d;
      spurious_q        <= spurious_d;
    end
  end

  // Binary level of the one-hot request; lowest set bit wins if several are ever present
  always_comb begin
    irq_level = '0;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt[i]) irq_level = 3'(i);
    end
  end

  // Highest-priority in-service bit, scanning from the level just above the lowest-priority one
  always_comb begin
    hlis       = '0;
    hlis_idx   = '0;
    hlis_valid = 1'b0;
    scan_idx   = '0;
    for (int i = 1; i <= 8; i++) begin
      scan_idx = priority_rotate_q + 3'(i);
      if (!hlis_valid && isr_q[scan_idx]) begin
        hlis_valid     = 1'b1;
        hlis_idx       = scan_idx;
        hlis[scan_idx] = 1'b1;
      end
    end
  end

  // Next state of the two-pulse INTA sequence; glitch falls in ACK1 and extra falls in ACK2 are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (inta_fall) state_d = S_ACK1;
      S_ACK1:      if (inta_rise) state_d = S_ACK1_DONE;
      S_ACK1_DONE: if (inta_fall) state_d = S_ACK2;
      S_ACK2:      if (inta_rise) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (init_strobe) state_d = S_IDLE;
  end

  // Datapath next values: acknowledge side effects, AEOI, then OCW2 which overrides AEOI rotation
  always_comb begin
    int_out_d         = 1'b0;
    clear_irr_d       = '0;
    data_out_d        = data_out_q;
    data_out_en_d     = data_out_en_q;
    level_d           = level_q;
    spurious_d        = spurious_q;
    rotate_aeoi_d     = rotate_aeoi_q;
    priority_rotate_d = priority_rotate_q;
    ack_set           = '0;
    eoi_clear         = '0;

    case (state_q)
      S_IDLE: begin
        int_out_d = (interrupt != 8'h00) && !inta_fall;
        if (inta_fall) begin
          spurious_d  = (interrupt == 8'h00);
          level_d     = (interrupt == 8'h00) ? SPURIOUS_LEVEL : irq_level;
          ack_set     = interrupt;
          clear_irr_d = interrupt;
        end
      end
      S_ACK1_DONE: begin
        if (inta_fall) begin
          data_out_d    = {vector_base, level_q};
          data_out_en_d = 1'b1;
        end
      end
      S_ACK2: begin
        if (inta_rise) begin
          data_out_en_d = 1'b0;
          if (aeoi_mode && !spurious_q) begin
            eoi_clear[level_q] = 1'b1;
            if (rotate_aeoi_q) priority_rotate_d = level_q;
          end
        end
      end
      default: ;
    endcase

    if (ocw2_strobe) begin
      case (ocw2[7:5])
        3'b001: eoi_clear = eoi_clear | hlis;
        3'b011: eoi_clear[ocw2[2:0]] = 1'b1;
        3'b101: begin
          eoi_clear = eoi_clear | hlis;
          if (hlis_valid) priority_rotate_d = hlis_idx;
        end
        3'b111: begin
          eoi_clear[ocw2[2:0]] = 1'b1;
          priority_rotate_d    = ocw2[2:0];
        end
        3'b100:  rotate_aeoi_d = 1'b1;
        3'b000:  rotate_aeoi_d = 1'b0;
        3'b110:  priority_rotate_d = ocw2[2:0];
        default: ;
      endcase
    end

    // A same-cycle acknowledge set beats any EOI clear of that bit
    isr_d = (isr_q & ~eoi_clear) | ack_set;

    if (init_strobe) begin
      int_out_d         = 1'b0;
      clear_irr_d       = '0;
      isr_d             = '0;
      priority_rotate_d = 3'b111;
      data_out_d        = '0;
      data_out_en_d     = 1'b0;
      rotate_aeoi_d     = 1'b0;
      level_d           = '0;
      spurious_d        = 1'b0;
    end
  end

  assign cpu.int_out               = int_out_q;
  assign cpu.data_out              = data_out_q;
  assign cpu.data_out_en           = data_out_en_q;
  assign clear_irr                 = clear_irr_q;
  assign isr                       = isr_q;
  assign priority_rotate           = priority_rotate_q;
  assign highest_level_in_service  = hlis;

endmodule

// File: tb/tb_pic_interrupt_acknowledge_control.sv
// tb/tb_pic_interrupt_acknowledge_control.sv - scoreboard bench for the PIC acknowledge block
module tb_pic_interrupt_acknowledge_control;
  logic       clk;
  logic       rst_n;
  logic [7:0] interrupt;
  logic       init_strobe;
  logic       aeoi_mode;
  logic [4:0] vector_base;
  logic       ocw2_strobe;
  logic [7:0] ocw2;
  logic [7:0] clear_irr;
  logic [7:0] isr;
  logic [7:0] hlis;
  logic [2:0] priority_rotate;

  pic_interrupt_acknowledge_control_if cpu_if ();

  pic_interrupt_acknowledge_control dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .interrupt                (interrupt),
    .init_strobe              (init_strobe),
    .aeoi_mode                (aeoi_mode),
    .vector_base              (vector_base),
    .ocw2_strobe              (ocw2_strobe),
    .ocw2                     (ocw2),
    .cpu                      (cpu_if),
    .clear_irr                (clear_irr),
    .isr                      (isr),
    .highest_level_in_service (hlis),
    .priority_rotate          (priority_rotate)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] clr_q[$];
  logic [7:0] vec_q[$];
  logic       den_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ocw2(input logic [7:0] v);
    ocw2 = v;
    ocw2_strobe = 1'b1;
    tick();
    ocw2_strobe = 1'b0;
  endtask

  task automatic ack(input logic [7:0] irq, input logic [7:0] vec);
    interrupt = irq;
    tick();
    if (irq != 8'h00) clr_q.push_back(irq);
    vec_q.push_back(vec);
    cpu_if.inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    tick();
    cpu_if.inta_n = 1'b0;
    tick();
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    tick();
  endtask

  // Monitor: compares IRR clear pulses and presented vectors against the expected queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (clear_irr != 8'h00) begin
        if (clr_q.size() == 0) chk("clear_irr_unexpected", clear_irr, 8'h00);
        else chk("clear_irr", clear_irr, clr_q.pop_front());
      end
      if (cpu_if.data_out_en && !den_prev) begin
        if (vec_q.size() == 0) chk("vector_unexpected", 1, 0);
        else chk("vector", cpu_if.data_out, vec_q.pop_front());
      end
    end
    den_prev <= cpu_if.data_out_en;
  end

  initial begin
    rst_n = 1'b0;
    interrupt = 8'h00;
    init_strobe = 1'b0;
    aeoi_mode = 1'b0;
    vector_base = 5'b01000;
    ocw2_strobe = 1'b0;
    ocw2 = 8'h00;
    cpu_if.inta_n = 1'b1;
    tick();
    tick();
    chk("rst_int_out", cpu_if.int_out, 0);
    chk("rst_isr", isr, 8'h00);
    chk("rst_prio", priority_rotate, 3'd7);
    chk("rst_den", cpu_if.data_out_en, 0);
    chk("rst_data_out", cpu_if.data_out, 8'h00);
    rst_n = 1'b1;
    tick();

    // basic acknowledge of IR2 with the request held throughout
    interrupt = 8'h04;
    tick();
    chk("int_out_rise", cpu_if.int_out, 1);
    clr_q.push_back(8'h04);
    cpu_if.inta_n = 1'b0;
    tick();
    chk("isr_after_fall", isr, 8'h04);
    chk("int_out_ack1", cpu_if.int_out, 0);
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    chk("int_out_ack1_done", cpu_if.int_out, 0);
    tick();
    vec_q.push_back(8'h42);
    cpu_if.inta_n = 1'b0;
    tick();
    chk("den_ack2", cpu_if.data_out_en, 1);
    chk("data_out_ack2", cpu_if.data_out, 8'h42);
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    chk("den_off", cpu_if.data_out_en, 0);
    chk("int_out_still_low", cpu_if.int_out, 0);
    tick();
    chk("int_out_reeval", cpu_if.int_out, 1);
    interrupt = 8'h00;
    tick();
    send_ocw2(8'h62);
    chk("spec_eoi_l2", isr, 8'h00);

    // spurious acknowledge
    ack(8'h00, 8'h47);
    chk("spurious_isr", isr, 8'h00);

    // non-specific then specific EOI
    ack(8'h02, 8'h41);
    ack(8'h08, 8'h43);
    chk("isr_0a", isr, 8'h0A);
    chk("hlis_02", hlis, 8'h02);
    send_ocw2(8'h20);
    chk("ns_eoi", isr, 8'h08);
    send_ocw2(8'h63);
    chk("spec_eoi_l3", isr, 8'h00);

    // rotate on non-specific EOI and rotated priority
    ack(8'h20, 8'h45);
    send_ocw2(8'hA0);
    chk("rot_ns_isr", isr, 8'h00);
    chk("rot_ns_prio", priority_rotate, 3'd5);
    ack(8'h01, 8'h40);
    ack(8'h40, 8'h46);
    chk("hlis_40", hlis, 8'h40);
    send_ocw2(8'h20);
    chk("ns_eoi_rot1", isr, 8'h01);
    send_ocw2(8'h20);
    chk("ns_eoi_rot2", isr, 8'h00);
    send_ocw2(8'hA0);
    chk("rot_ns_empty_prio", priority_rotate, 3'd5);
    chk("hlis_empty", hlis, 8'h00);

    // automatic EOI with rotation, then set priority
    aeoi_mode = 1'b1;
    send_ocw2(8'h80);
    ack(8'h04, 8'h42);
    chk("aeoi_isr", isr, 8'h00);
    chk("aeoi_prio", priority_rotate, 3'd2);
    send_ocw2(8'hC6);
    chk("set_prio", priority_rotate, 3'd6);
    aeoi_mode = 1'b0;
    send_ocw2(8'h00);

    // synchronous init
    ack(8'h02, 8'h41);
    chk("pre_init_isr", isr, 8'h02);
    init_strobe = 1'b1;
    tick();
    init_strobe = 1'b0;
    chk("init_isr", isr, 8'h00);
    chk("init_prio", priority_rotate, 3'd7);

    // reset in the middle of a sequence
    ack(8'h08, 8'h43);
    send_ocw2(8'h63);
    interrupt = 8'h10;
    tick();
    clr_q.push_back(8'h10);
    cpu_if.inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    tick();
    cpu_if.inta_n = 1'b1;
    tick();
    chk("mid_isr", isr, 8'h10);
    rst_n = 1'b0;
    #1;
    chk("arst_isr", isr, 8'h00);
    chk("arst_data_out", cpu_if.data_out, 8'h00);
    chk("arst_prio", priority_rotate, 3'd7);
    chk("arst_int_out", cpu_if.int_out, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ack(8'h01, 8'h40);
    chk("post_rst_isr", isr, 8'h01);
    chk("post_rst_data", cpu_if.data_out, 8'h40);
    chk("post_rst_den", cpu_if.data_out_en, 0);
    tick();

    chk("clr_q_drained", clr_q.size(), 0);
    chk("vec_q_drained", vec_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pic_interrupt_acknowledge_control.md
Name: pic_interrupt_acknowledge_control

Overview:
- CPU-facing consumer of the PIC priority resolver's one-hot interrupt request.
- Raises INT to the CPU and runs the 8086-mode two-pulse INTA acknowledge sequence.
- Owns the In-Service Register: sets ISR bits on acknowledge, clears IRR latches, and drives the vector byte.
- Executes OCW2 EOI/rotate commands and holds the priority_rotate and highest-level-in-service values that feed back into the resolver.

Parameters:
- SPURIOUS_LEVEL, 3'd7, IR level reported in the vector when no request is present at the first INTA.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- interrupt  input  8  one-hot resolved request from the priority resolver; 0 = none.
- inta_n  input  1  CPU interrupt acknowledge, active-low, already synchronous to clk.
- init_strobe  input  1  one-cycle pulse on an ICW1 write.
- aeoi_mode  input  1  ICW4 automatic-EOI enable.
- vector_base  input  5  ICW2 bits T7..T3.
- ocw2_strobe  input  1  one-cycle pulse on an OCW2 write.
- ocw2  input  8  OCW2 byte: R,SL,EOI = [7:5], L = [2:0].
- int_out  output  1  INT request to the CPU.
- clear_irr  output  8  one-cycle pulse that clears IRR latch bits.
- isr  output  8  In-Service Register.
- highest_level_in_service  output  8  one-hot highest-priority set ISR bit under the current rotation; 0 if ISR = 0.
- priority_rotate  output  3  lowest-priority IR level.
- data_out  output  8  vector byte.
- data_out_en  output  1  data bus drive enable.

Behaviour:
- Reset values (rst_n low, immediate): int_out=0, clear_irr=0, isr=0, priority_rotate=3'b111, data_out=0, data_out_en=0, rotate_aeoi=0, state IDLE. Asserting rst_n mid-sequence aborts the sequence.
- init_strobe: same effect as reset, synchronous.
- Priority order: IR(priority_rotate+1 mod 8) highest, IR(priority_rotate) lowest. highest_level_in_service is combinational from isr and priority_rotate.
- INTA edges: fall = inta_n_q=1 & inta_n=0; rise = inta_n_q=0 & inta_n=1, where inta_n_q is a registered copy of inta_n.
- IDLE:
  - int_out = (interrupt != 0), registered, so it follows interrupt with 1-cycle latency.
  - On fall: go to ACK1 and set int_out=0.
  - If interrupt != 0: latch level = encode(interrupt), isr |= interrupt, clear_irr = interrupt for exactly 1 cycle.
  - If interrupt == 0: spurious; level = SPURIOUS_LEVEL, no ISR or IRR change.
- ACK1: wait for rise, then go to ACK1_DONE.
- ACK1_DONE: on fall, data_out = {vector_base, level} and data_out_en=1 from the next cycle until rise; go to ACK2.
- ACK2: on rise, set data_out_en=0 and go to IDLE.
  - If aeoi_mode and not spurious: isr[level] cleared on that cycle.
  - If rotate_aeoi is also set: priority_rotate <= level.
- int_out stays 0 from the first fall until back in IDLE; it re-evaluates on the cycle after entering IDLE.
- OCW2 on ocw2_strobe, decoded by R,SL,EOI:
  - 001 non-specific EOI: clear the highest_level_in_service bit.
  - 011 specific EOI: clear isr[L].
  - 101 rotate on non-specific EOI: clear the highest bit; priority_rotate <= its index.
  - 111 rotate on specific EOI: clear isr[L]; priority_rotate <= L.
  - 100 set rotate_aeoi; 000 clear rotate_aeoi.
  - 110 set priority: priority_rotate <= L.
  - 010 no-op.
  - Non-specific EOI with isr=0: no ISR change; rotate variant leaves priority_rotate unchanged.
- Simultaneous events: isr_next = (isr & ~eoi_clear) | ack_set, so a set of the same bit wins. If OCW2 and AEOI both write priority_rotate in one cycle, OCW2 wins.
- A third INTA fall, or a fall in ACK1 (glitch), is ignored until IDLE.

Test Plan:
- Reset, then interrupt=8'h04, vector_base=5'b01000: int_out=1 one cycle later. Two INTA pulses: isr=8'h04, clear_irr=8'h04 for 1 cycle after the first fall, data_out=8'h42 with data_out_en=1 during the second pulse, int_out=0 until IDLE.
- interrupt=0 at the first INTA fall: isr stays 0, clear_irr stays 0, vector = {vector_base,3'd7}.
- isr=8'h0A, priority_rotate=7, OCW2 8'h20: isr=8'h08. Then OCW2 8'h63 (specific EOI, L=3): isr=0.
- isr=8'h20, OCW2 8'hA0: isr=0, priority_rotate=5. Check highest_level_in_service=8'h40 for isr=8'h41.
- aeoi_mode=1, OCW2 8'h80, then acknowledge IR2: after the second rise isr=0 and priority_rotate=2. OCW2 8'hC6: priority_rotate=6.
- Assert rst_n low during ACK1_DONE: all outputs return to reset values immediately. The next INTA pair with interrupt=8'h01 completes normally.
